// File: rtl/lc4_pkg.sv
// Shared LC4 decode definitions: opcodes, instruction field positions and the
// per-opcode flag table.
package lc4_pkg;

   localparam int unsigned OPC_W            = 5;
   localparam int unsigned LINK_REG_DEFAULT = 7;

   // Register fields are packed REG_W-wide slots below the opcode: rd | rs | rt
   localparam int unsigned RD_FIELD = 2;
   localparam int unsigned RS_FIELD = 1;
   localparam int unsigned RT_FIELD = 0;

   localparam logic [OPC_W-1:0] OP_NOP   = 5'b00000;
   localparam logic [OPC_W-1:0] OP_BRZ   = 5'b00001;
   localparam logic [OPC_W-1:0] OP_BRZP  = 5'b00010;
   localparam logic [OPC_W-1:0] OP_BRNP  = 5'b00011;
   localparam logic [OPC_W-1:0] OP_BRNZ  = 5'b00100;
   localparam logic [OPC_W-1:0] OP_ADD   = 5'b00101;
   localparam logic [OPC_W-1:0] OP_SUB   = 5'b00110;
   localparam logic [OPC_W-1:0] OP_ADDI  = 5'b00111;
   localparam logic [OPC_W-1:0] OP_JSR   = 5'b01000;
   localparam logic [OPC_W-1:0] OP_ANDI  = 5'b01001;
   localparam logic [OPC_W-1:0] OP_RTI   = 5'b01010;
   localparam logic [OPC_W-1:0] OP_CONST = 5'b01011;
   localparam logic [OPC_W-1:0] OP_SLL   = 5'b01100;
   localparam logic [OPC_W-1:0] OP_SRL   = 5'b01101;
   localparam logic [OPC_W-1:0] OP_SDRH  = 5'b01110;
   localparam logic [OPC_W-1:0] OP_SDRL  = 5'b01111;

   typedef struct packed {
      logic r1re;
      logic r2re;
      logic regfile_we;
      logic nzp_we;
      logic select_pc_plus_one;
      logic is_branch;
      logic is_control_insn;
      logic illegal;
   } dec_flags_t;

   function automatic dec_flags_t decode_flags(input logic [OPC_W-1:0] op);
      dec_flags_t f;
      f = '0;
      case (op)
         OP_NOP, OP_BRZ, OP_BRZP, OP_BRNP, OP_BRNZ: f.is_branch = 1'b1;
         OP_ADD, OP_SUB, OP_SLL, OP_SRL, OP_SDRH, OP_SDRL: begin
            f.r1re       = 1'b1;
            f.r2re       = 1'b1;
            f.regfile_we = 1'b1;
         end
         OP_ADDI, OP_ANDI: begin
            f.r1re       = 1'b1;
            f.regfile_we = 1'b1;
         end
         OP_CONST: f.regfile_we = 1'b1;
         OP_JSR: begin
            f.regfile_we         = 1'b1;
            f.select_pc_plus_one = 1'b1;
            f.is_control_insn    = 1'b1;
         end
         OP_RTI:  f.is_control_insn = 1'b1;
         default: f.illegal = 1'b1;
      endcase
      f.nzp_we = f.regfile_we;
      return f;
   endfunction

endpackage

// File: rtl/lc4_insn_decode.sv
// Combinational field and flag decode of one LC4 instruction word.
module lc4_insn_decode
   import lc4_pkg::*;
#(
   parameter int unsigned INSN_W   = 20,
   parameter int unsigned REG_W    = 5,
   parameter int unsigned LINK_REG = LINK_REG_DEFAULT
) (
   input  logic [INSN_W-1:0] insn,
   output logic [REG_W-1:0]  r1sel_c,
   output logic [REG_W-1:0]  r2sel_c,
   output logic [REG_W-1:0]  wsel_c,
   output dec_flags_t        flags_c
);

   logic [OPC_W-1:0] opcode;

   assign opcode = insn[INSN_W-1 -: OPC_W];

   always_comb begin
      flags_c = decode_flags(opcode);
      r1sel_c = insn[RS_FIELD*REG_W +: REG_W];
      r2sel_c = insn[RT_FIELD*REG_W +: REG_W];
      wsel_c  = (opcode == OP_JSR) ? REG_W'(LINK_REG) : insn[RD_FIELD*REG_W +: REG_W];
   end

endmodule

// File: rtl/lc4_decode_stage.sv
// LC4 decode stage: one-entry instruction holding register with register/NZP
// scoreboard, hazard stall, flush, and valid/ready on both sides.
module lc4_decode_stage
   import lc4_pkg::*;
#(
   parameter int unsigned INSN_W   = 20,
   parameter int unsigned REG_W    = 5,
   parameter int unsigned PC_W     = 16,
   parameter int unsigned LINK_REG = LINK_REG_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [INSN_W-1:0] in_insn,
   input  logic [PC_W-1:0]   in_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PC_W-1:0]   out_pc,
   output logic [REG_W-1:0]  out_r1sel,
   output logic [REG_W-1:0]  out_r2sel,
   output logic [REG_W-1:0]  out_wsel,
   output logic              out_r1re,
   output logic              out_r2re,
   output logic              out_regfile_we,
   output logic              out_nzp_we,
   output logic              out_select_pc_plus_one,
   output logic              out_is_branch,
   output logic              out_is_control_insn,
   output logic              out_illegal,
   input  logic              wb_valid,
   input  logic [REG_W-1:0]  wb_sel,
   input  logic              wb_nzp,
   input  logic              flush
);

   localparam int unsigned NREG = 1 << REG_W;

   logic              held_valid;
   logic [INSN_W-1:0] held_insn;
   logic [PC_W-1:0]   held_pc;
   logic [NREG-1:0]   pending;
   logic              nzp_pending;

   logic [REG_W-1:0]  dec_r1sel;
   logic [REG_W-1:0]  dec_r2sel;
   logic [REG_W-1:0]  dec_wsel;
   dec_flags_t        dec_flags;
   dec_flags_t        vis_flags;

   logic [NREG-1:0]   wb_mask;
   logic [NREG-1:0]   eff_pend;
   logic [NREG-1:0]   pending_n;
   logic              eff_nzp;
   logic              nzp_pending_n;
   logic              hazard;
   logic              issue;
   logic              load;

   lc4_insn_decode #(
      .INSN_W   (INSN_W),
      .REG_W    (REG_W),
      .LINK_REG (LINK_REG)
   ) u_decode (
      .insn    (held_insn),
      .r1sel_c (dec_r1sel),
      .r2sel_c (dec_r2sel),
      .wsel_c  (dec_wsel),
      .flags_c (dec_flags)
   );

   // Writeback clears are seen by the hazard check in the same cycle they retire
   always_comb begin
      wb_mask = '0;
      if (wb_valid) wb_mask[wb_sel] = 1'b1;
      eff_pend = pending & ~wb_mask;
      eff_nzp  = nzp_pending & ~wb_nzp;
      hazard   = (dec_flags.r1re       & eff_pend[dec_r1sel])
               | (dec_flags.r2re       & eff_pend[dec_r2sel])
               | (dec_flags.regfile_we & eff_pend[dec_wsel])
               | (dec_flags.is_branch  & eff_nzp);
      out_valid = held_valid & ~hazard & ~flush;
      issue     = out_valid & out_ready;
      in_ready  = ~flush & (~held_valid | issue);
      load      = in_valid & in_ready;
   end

   // Issue sets are applied after writeback clears so a same-register set wins
   always_comb begin
      pending_n = eff_pend;
      if (issue && dec_flags.regfile_we) pending_n[dec_wsel] = 1'b1;
      nzp_pending_n = eff_nzp | (issue & dec_flags.nzp_we);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         held_valid  <= 1'b0;
         held_insn   <= '0;
         held_pc     <= '0;
         pending     <= '0;
         nzp_pending <= 1'b0;
      end else if (flush) begin
         held_valid  <= 1'b0;
         pending     <= '0;
         nzp_pending <= 1'b0;
      end else begin
         pending     <= pending_n;
         nzp_pending <= nzp_pending_n;
         if (load) begin
            held_valid <= 1'b1;
            held_insn  <= in_insn;
            held_pc    <= in_pc;
         end else if (issue) begin
            held_valid <= 1'b0;
         end
      end
   end

   // Decode outputs read as zero whenever the stage is empty
   always_comb begin
      vis_flags = held_valid ? dec_flags : '0;
      out_pc    = held_valid ? held_pc   : '0;
      out_r1sel = held_valid ? dec_r1sel : '0;
      out_r2sel = held_valid ? dec_r2sel : '0;
      out_wsel  = held_valid ? dec_wsel  : '0;
      out_r1re               = vis_flags.r1re;
      out_r2re               = vis_flags.r2re;
      out_regfile_we         = vis_flags.regfile_we;
      out_nzp_we             = vis_flags.nzp_we;
      out_select_pc_plus_one = vis_flags.select_pc_plus_one;
      out_is_branch          = vis_flags.is_branch;
      out_is_control_insn    = vis_flags.is_control_insn;
      out_illegal            = vis_flags.illegal;
   end

endmodule

// File: doc/lc4_decode_stage.md
Name: lc4_decode_stage

Overview:
- Registered, parametrised LC4 decode stage; sits between fetch and execute.
- Holds one instruction and decodes its opcode and register fields (widths parametrised).
- Tracks in-flight register and NZP writes in a scoreboard; stalls RAW/WAW and branch-on-pending-NZP hazards; supports flush.
- Valid/ready handshake on both sides.

Parameters:
INSN_W, 20, instruction width; must be >= 5 + 3*REG_W
REG_W, 5, register-select width; scoreboard has 2**REG_W entries
PC_W, 16, program-counter width carried alongside the instruction
LINK_REG, 7, register written by JSR

Ports:
clk  in  1  clock
rst  in  1  reset
in_valid  in  1  fetch offers instruction
in_ready  out  1  stage can accept
in_insn  in  INSN_W  instruction
in_pc  in  PC_W  its PC
out_valid  out  1  decoded instruction hazard-free and offered
out_ready  in  1  execute accepts
out_pc  out  PC_W  held PC
out_r1sel, out_r2sel, out_wsel  out  REG_W  rs, rt, rd
out_r1re, out_r2re, out_regfile_we, out_nzp_we, out_select_pc_plus_one, out_is_branch, out_is_control_insn, out_illegal  out  1 each  decode flags
wb_valid  in  1  register writeback retiring
wb_sel  in  REG_W  register written back
wb_nzp  in  1  NZP write retiring
flush  in  1  kill held instruction, clear scoreboard

Interface: one clock; reset is asynchronous and active-high. Ports are clk and rst.

Behaviour:
- Fields: opcode = insn[INSN_W-1 -: 5]; rd = insn[3*REG_W-1:2*REG_W]; rs = insn[2*REG_W-1:REG_W]; rt = insn[REG_W-1:0].
- Opcodes:
  - 00000 NOP, 00001 BRz, 00010 BRzp, 00011 BRnp, 00100 BRnz: is_branch.
  - 00101 ADD, 00110 SUB, 01100 SLL, 01101 SRL, 01110 SDRH, 01111 SDRL: r1re, r2re, regfile_we.
  - 00111 ADDI, 01001 ANDI: r1re, regfile_we.
  - 01011 CONST: regfile_we.
  - 01000 JSR: regfile_we, wsel=LINK_REG, select_pc_plus_one, is_control_insn.
  - 01010 RTI: is_control_insn.
  - Any other opcode: illegal=1, all other flags 0.
  - For all opcodes: nzp_we = regfile_we; wsel = rd except JSR.
- State:
  - held_valid, held_insn, held_pc.
  - pending[2**REG_W] register scoreboard.
  - nzp_pending.
- Reset: held_valid=0, held_insn=0, held_pc=0, pending=0, nzp_pending=0. in_ready=1, out_valid=0, all out_* fields 0.
- When held_valid=0, all out_* decode fields are forced to 0.
- Effective pending: eff_pend[r] = pending[r] & ~(wb_valid & wb_sel==r). Writeback clears are visible to the hazard check in the same cycle.
- Effective NZP pending: eff_nzp = nzp_pending & ~wb_nzp.
- hazard = (r1re & eff_pend[rs]) | (r2re & eff_pend[rt]) | (regfile_we & eff_pend[wsel]) | (is_branch & eff_nzp).
- out_valid = held_valid & ~hazard & ~flush.
- issue = out_valid & out_ready.
- in_ready = ~flush & (~held_valid | issue).
- Load: in_valid & in_ready captures in_insn/in_pc at the edge; decoded fields appear the next cycle (1-cycle latency). Back-to-back accept occurs when issue happens in the same cycle. Otherwise held_valid clears on issue.
- Scoreboard set on issue:
  - regfile_we sets pending[wsel].
  - nzp_we sets nzp_pending.
  - Set wins over a same-cycle wb clear of the same register.
- Scoreboard clear: wb_valid clears pending[wb_sel]; wb_nzp clears nzp_pending.
- flush: next cycle held_valid=0, pending=0, nzp_pending=0. Same-cycle input is not captured and no issue occurs.
- wb_valid for a non-pending register: no effect.
- Illegal instruction issues normally (no hazards); downstream traps.
- rst mid-operation: immediate return to reset state.

Decomposition:
- Package lc4_pkg: opcode localparams (OP_NOP..OP_SDRL), field-slice helper constants, default LINK_REG.
- Sub-module lc4_insn_decode: purely combinational, parametrised field/flag decode. Instantiated on held_insn.
- Scoreboard and handshake logic stay in lc4_decode_stage.

Test Plan:
- Reset, then ADD r3,r1,r2 (0x28C22) with out_ready=1 -> out_valid next cycle, r1sel=1, r2sel=2, wsel=3, regfile_we=1, nzp_we=1; pending[3]=1 after issue.
- ADD writes r3, then SUB r4,r3,r1 with no wb -> out_valid=0, in_ready=0 (stall). Assert wb_valid, wb_sel=3 -> SUB issues that same cycle.
- JSR issued -> wsel=7, select_pc_plus_one=1, is_control_insn=1. Next, BRz before wb_nzp -> stalled; wb_nzp=1 -> branch issues.
- out_ready=0 holding ADDI while in_valid=1 -> in_ready=0, fields stable. out_ready=1 -> issue and new instruction captured on the same edge.
- flush with pending[3], nzp_pending set and held SLL -> next cycle out_valid=0, all pending cleared, input offered during flush is dropped.
- Opcode 11111 -> illegal=1, other flags 0, issues. Assert rst mid-stall -> all outputs 0 immediately.
